vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, axis phase type and total helper for the VGA raster generator.
package vga_timing_pkg;

  // 640x480@60 defaults
  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam bit          DEF_H_SYNC_POL = 1'b0;
  localparam bit          DEF_V_SYNC_POL = 1'b0;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_phase_t;

  function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sw, input int unsigned bp);
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: 16-bit position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// o_phase and o_sync_window describe the state entered on this step, so callers can register them.
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_step,
  output logic [15:0]                 o_count,
  output vga_timing_pkg::axis_phase_t o_phase,
  output logic                        o_wrap,
  output logic                        o_sync_window
);

  localparam int unsigned TOTAL   = vga_timing_pkg::axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [15:0] LAST    = 16'(TOTAL - 1);
  localparam logic [15:0] B_FRONT = 16'(ACTIVE);
  localparam logic [15:0] B_SYNC  = 16'(ACTIVE + FP);
  localparam logic [15:0] B_BACK  = 16'(ACTIVE + FP + SYNC);

  generate
    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 || TOTAL > 65535) begin : g_bad_timing
      $error("vga_axis_counter: zero-length interval or total above 65535");
    end
  endgenerate

  logic [15:0]                 count_q, count_d;
  vga_timing_pkg::axis_phase_t phase_q, phase_d;

  assign o_wrap = (count_q == LAST);

  // Phase follows the next count, so FSM and counter always agree after the edge.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (i_step) begin
      count_d = o_wrap ? 16'd0 : count_q + 16'd1;
      case (phase_q)
        vga_timing_pkg::ACTIVE: if (count_d == B_FRONT) phase_d = vga_timing_pkg::FRONT;
        vga_timing_pkg::FRONT:  if (count_d == B_SYNC)  phase_d = vga_timing_pkg::SYNC;
        vga_timing_pkg::SYNC:   if (count_d == B_BACK)  phase_d = vga_timing_pkg::BACK;
        vga_timing_pkg::BACK:   if (count_d == 16'd0)   phase_d = vga_timing_pkg::ACTIVE;
        default:                phase_d = vga_timing_pkg::BACK;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= LAST;
      phase_q <= vga_timing_pkg::BACK;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign o_count       = count_q;
  assign o_phase       = phase_d;
  assign o_sync_window = (phase_d == vga_timing_pkg::SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, syncs, data-enable and line/frame markers.
// Define VGA_TIMING_SYNC_DLY_EN to delay every marker (not o_x/o_y) by one extra pixel step.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          H_SYNC_POL = DEF_H_SYNC_POL,
  parameter bit          V_SYNC_POL = DEF_V_SYNC_POL
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam logic HS_OFF = ~H_SYNC_POL;
  localparam logic VS_OFF = ~V_SYNC_POL;

  logic        h_wrap, v_wrap, h_sync_win, v_sync_win, v_step;
  axis_phase_t h_phase, v_phase;

  assign v_step = i_pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_step        (i_pix_en),
    .o_count       (o_x),
    .o_phase       (h_phase),
    .o_wrap        (h_wrap),
    .o_sync_window (h_sync_win)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_step        (v_step),
    .o_count       (o_y),
    .o_phase       (v_phase),
    .o_wrap        (v_wrap),
    .o_sync_window (v_sync_win)
  );

  logic de_d, hs_d, vs_d, ls_d, fs_d;

  assign de_d = (h_phase == ACTIVE) && (v_phase == ACTIVE);
  assign hs_d = h_sync_win ? H_SYNC_POL : HS_OFF;
  assign vs_d = v_sync_win ? V_SYNC_POL : VS_OFF;
  assign ls_d = h_wrap;
  assign fs_d = h_wrap & v_wrap;

  logic de_q, hs_q, vs_q, ls_q, fs_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_q <= 1'b0;
      hs_q <= HS_OFF;
      vs_q <= VS_OFF;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      if (i_pix_en) begin
        de_q <= de_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
      end
`ifdef VGA_TIMING_SYNC_DLY_EN
      // Start markers held as levels here; the delay stage turns them into pulses.
      if (i_pix_en) begin
        ls_q <= ls_d;
        fs_q <= fs_d;
      end
`else
      ls_q <= i_pix_en & ls_d;
      fs_q <= i_pix_en & fs_d;
`endif
    end
  end

`ifdef VGA_TIMING_SYNC_DLY_EN
  logic de_dly_q, hs_dly_q, vs_dly_q, ls_dly_q, fs_dly_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_dly_q <= 1'b0;
      hs_dly_q <= HS_OFF;
      vs_dly_q <= VS_OFF;
      ls_dly_q <= 1'b0;
      fs_dly_q <= 1'b0;
    end else begin
      if (i_pix_en) begin
        de_dly_q <= de_q;
        hs_dly_q <= hs_q;
        vs_dly_q <= vs_q;
      end
      ls_dly_q <= i_pix_en & ls_q;
      fs_dly_q <= i_pix_en & fs_q;
    end
  end

  assign o_de          = de_dly_q;
  assign o_h_sync      = hs_dly_q;
  assign o_v_sync      = vs_dly_q;
  assign o_line_start  = ls_dly_q;
  assign o_frame_start = fs_dly_q;
`else
  assign o_de          = de_q;
  assign o_h_sync      = hs_q;
  assign o_v_sync      = vs_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 7x5 instance share stimulus
// and are checked each cycle against a position-from-enable-count model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] d_x, d_y, t_x, t_y;
  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic t_hs, t_vs, t_de, t_ls, t_fs;

  vga_timing_gen u_dflt (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
    .o_x(d_x), .o_y(d_y), .o_h_sync(d_hs), .o_v_sync(d_vs), .o_de(d_de),
    .o_line_start(d_ls), .o_frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_tiny (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
    .o_x(t_x), .o_y(t_y), .o_h_sync(t_hs), .o_v_sync(t_vs), .o_de(t_de),
    .o_line_start(t_ls), .o_frame_start(t_fs)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    longint x, y;
    bit hs, vs, de, ls, fs;
  } exp_t;

  // Everything follows from n = enables since reset: position (n-1) mod frame,
  // markers from the same position (or one enable earlier with the delay stage).
  function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input longint n, input bit en);
    exp_t   e;
    longint ht, vt, ft, idx, mk, mx, my;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = ht * vt;
    if (n == 0) begin
      e.x = ht - 1; e.y = vt - 1;
    end else begin
      idx = (n - 1) % ft; e.x = idx % ht; e.y = idx / ht;
    end
`ifdef VGA_TIMING_SYNC_DLY_EN
    mk = n - 1;
`else
    mk = n;
`endif
    if (mk <= 0) begin
      e.de = 0; e.hs = 1; e.vs = 1; e.ls = 0; e.fs = 0;
    end else begin
      idx = (mk - 1) % ft; mx = idx % ht; my = idx / ht;
      e.de = (mx < ha) && (my < va);
      e.hs = !((mx >= ha + hf) && (mx < ha + hf + hsw));
      e.vs = !((my >= va + vf) && (my < va + vf + vsw));
      e.ls = en && (mx == 0);
      e.fs = en && (mx == 0) && (my == 0);
    end
    return e;
  endfunction

  longint n = 0;
  bit     en_l = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n    <= 0;
      en_l <= 1'b0;
    end else begin
      en_l <= pix_en;
      if (pix_en) n <= n + 1;
    end
  end

  exp_t e_d, e_t;

  always @(negedge clk) begin
    e_d = model(640, 16, 96, 48, 480, 10, 2, 33, n, en_l);
    e_t = model(4, 1, 1, 1, 2, 1, 1, 1, n, en_l);
    chk("d_x", d_x, e_d.x);   chk("d_y", d_y, e_d.y);
    chk("d_hs", d_hs, e_d.hs); chk("d_vs", d_vs, e_d.vs);
    chk("d_de", d_de, e_d.de); chk("d_ls", d_ls, e_d.ls); chk("d_fs", d_fs, e_d.fs);
    chk("t_x", t_x, e_t.x);   chk("t_y", t_y, e_t.y);
    chk("t_hs", t_hs, e_t.hs); chk("t_vs", t_vs, e_t.vs);
    chk("t_de", t_de, e_t.de); chk("t_ls", t_ls, e_t.ls); chk("t_fs", t_fs, e_t.fs);
  end

  // Apply an enable value, then land just after the next active edge.
  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int  hcnt, hfirst, last_fs, nper, ticks, vcnt, dcnt;
    bit  reached;

    repeat (3) tick(1'b0);
    chk("rst_x", d_x, 799);  chk("rst_y", d_y, 524);
    chk("rst_hs", d_hs, 1);  chk("rst_vs", d_vs, 1);
    chk("rst_de", d_de, 0);  chk("rst_ls", d_ls, 0); chk("rst_fs", d_fs, 0);

    rst_n = 1'b1;
    tick(1'b1);
`ifdef VGA_TIMING_SYNC_DLY_EN
    chk("first_x", d_x, 0); chk("first_de", d_de, 0); chk("first_fs", d_fs, 0);
    tick(1'b1);
    chk("second_x", d_x, 1); chk("second_y", d_y, 0);
    chk("second_fs", d_fs, 1); chk("second_ls", d_ls, 1); chk("second_de", d_de, 1);
`else
    chk("first_x", d_x, 0); chk("first_y", d_y, 0);
    chk("first_fs", d_fs, 1); chk("first_ls", d_ls, 1); chk("first_de", d_de, 1);
`endif

    hcnt = 0; hfirst = -1; reached = 0; ticks = 0;
    for (int i = 0; i < 900; i++) begin
      tick(1'b1);
      ticks++;
      if (d_hs == 1'b0) begin
        if (hcnt == 0) hfirst = int'(d_x);
        hcnt++;
      end
      if (d_x == 16'd0 && d_y == 16'd1) begin
        reached = 1;
        break;
      end
    end
    chk("line1_reached", reached, 1);
    chk("hsync_width", hcnt, 96);
    chk("line1_fs", d_fs, 0);
`ifdef VGA_TIMING_SYNC_DLY_EN
    chk("line1_ticks", ticks, 799);
    chk("hsync_first_x", hfirst, 657);
    chk("line1_ls", d_ls, 0);
`else
    chk("line1_ticks", ticks, 800);
    chk("hsync_first_x", hfirst, 656);
    chk("line1_ls", d_ls, 1);
`endif

    repeat (3000) tick(1'($urandom_range(0, 1)));

    // Divide-by-4 strobe: tiny frame of 35 pixels must repeat every 140 clocks.
    last_fs = -1; nper = 0;
    for (int i = 0; i < 600; i++) begin
      tick(i % 4 == 0);
      if (t_fs) begin
        if (last_fs >= 0) begin
          chk("div4_frame_period", i - last_fs, 140);
          nper++;
        end
        last_fs = i;
      end
    end
    chk("div4_periods_seen", nper >= 3, 1);

    // Reset while the tiny instance is inside both sync windows.
    reached = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1);
      if (t_hs == 1'b0 && t_vs == 1'b0) begin
        reached = 1;
        break;
      end
    end
    chk("both_sync_reached", reached, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hs", t_hs, 1); chk("midrst_vs", t_vs, 1);
    chk("midrst_x", t_x, 6);   chk("midrst_y", t_y, 4);
    chk("midrst_dx", d_x, 799); chk("midrst_dy", d_y, 524);
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("post_rst_hs", t_hs, 1);
    tick(1'b1);
    chk("post_rst_x", t_x, 0); chk("post_rst_y", t_y, 0);

    hcnt = 0; vcnt = 0; dcnt = 0;
    repeat (35) begin
      tick(1'b1);
      if (t_hs == 1'b0) hcnt++;
      if (t_vs == 1'b0) vcnt++;
      if (t_de) dcnt++;
    end
    chk("tiny_hs_per_frame", hcnt, 5);
    chk("tiny_vs_per_frame", vcnt, 7);
    chk("tiny_de_per_frame", dcnt, 8);

    repeat (500) tick(1'($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
